fxp_sdiv: RTL and testbench

FXP_SDIV -- requirements
Module: fxp_sdiv

---
 rtl/fxp_sdiv_if.sv | 25 ++
 rtl/fxp_sdiv.sv | 141 ++++++++++++++
 tb/tb_fxp_sdiv.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_sdiv_if.sv
// Operand/result handshake bundle for the fixed-point signed divider.
// Both sides use valid/ready: a transfer happens on a cycle where valid && ready.
interface fxp_sdiv_if #(
    parameter int BIT_WIDTH = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, div_by_zero, overflow
    );
endinterface

// File: rtl/fxp_sdiv.sv
// Signed Q(QINT.QFRAC) divider: out = (a << QFRAC) / b, truncated toward zero,
// one restoring-division quotient bit per cycle with saturation on overflow.
module fxp_sdiv #(
    parameter int QINT  = 8,
    parameter int QFRAC = 16
) (
    input  logic        clk,
    input  logic        rst,
    fxp_sdiv_if.slave   bus,
    output logic [1:0]  o_dbg_state
);
    localparam int BIT_WIDTH = QINT + QFRAC;
    localparam int NITER     = BIT_WIDTH + QFRAC;
    localparam int CW        = $clog2(NITER + 1);

    localparam logic [BIT_WIDTH-1:0] MAX_OUT = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] MIN_OUT = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [NITER-1:0] POS_LIMIT = {{(NITER-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [NITER-1:0] NEG_LIMIT = {{(NITER-BIT_WIDTH){1'b0}}, 1'b1, {(BIT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [NITER-1:0]     r_num;
    logic [BIT_WIDTH-1:0] r_den;
    logic [BIT_WIDTH:0]   r_rem;
    logic [NITER-1:0]     r_quo;
    logic                 r_neg;
    logic [CW-1:0]        r_cnt;
    logic                 r_out_valid;
    logic [BIT_WIDTH-1:0] r_out;
    logic                 r_dbz;
    logic                 r_ovf;

    // Unsigned magnitudes; the most negative operand maps to 2^(BIT_WIDTH-1).
    logic [BIT_WIDTH-1:0] w_a_mag;
    logic [BIT_WIDTH-1:0] w_b_mag;
    assign w_a_mag = bus.a[BIT_WIDTH-1] ? (~bus.a + {{(BIT_WIDTH-1){1'b0}}, 1'b1}) : bus.a;
    assign w_b_mag = bus.b[BIT_WIDTH-1] ? (~bus.b + {{(BIT_WIDTH-1){1'b0}}, 1'b1}) : bus.b;

    logic [BIT_WIDTH:0]   w_rem_shift;
    logic                 w_ge;
    logic [BIT_WIDTH:0]   w_rem_next;
    logic [NITER-1:0]     w_quo_next;
    assign w_rem_shift = {r_rem[BIT_WIDTH-1:0], r_num[NITER-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_den});
    assign w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_den}) : w_rem_shift;
    assign w_quo_next  = {r_quo[NITER-2:0], w_ge};

    // Signed result from the final quotient; evaluated on the last iteration.
    logic [BIT_WIDTH-1:0] w_sat_out;
    logic                 w_sat_ovf;
    always_comb begin
        w_sat_out = '0;
        w_sat_ovf = 1'b0;
        if (!r_neg) begin
            if (w_quo_next <= POS_LIMIT) begin
                w_sat_out = w_quo_next[BIT_WIDTH-1:0];
            end else begin
                w_sat_out = MAX_OUT;
                w_sat_ovf = 1'b1;
            end
        end else begin
            if (w_quo_next <= NEG_LIMIT) begin
                w_sat_out = ~w_quo_next[BIT_WIDTH-1:0] + {{(BIT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                w_sat_out = MIN_OUT;
                w_sat_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_b_mag == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_dbz       <= 1'b1;
                            r_ovf       <= 1'b0;
                            r_out       <= bus.a[BIT_WIDTH-1] ? MIN_OUT : MAX_OUT;
                        end else begin
                            r_state <= S_BUSY;
                            r_num   <= {w_a_mag, {QFRAC{1'b0}}};
                            r_den   <= w_b_mag;
                            r_rem   <= '0;
                            r_quo   <= '0;
                            r_neg   <= bus.a[BIT_WIDTH-1] ^ bus.b[BIT_WIDTH-1];
                            r_cnt   <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_num <= {r_num[NITER-2:0], 1'b0};
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == CW'(NITER - 1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out       <= w_sat_out;
                        r_ovf       <= w_sat_ovf;
                        r_dbz       <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.out         = r_out;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_fxp_sdiv.sv
// Bench for fxp_sdiv: directed corner cases plus random operands, all checked
// against an integer-arithmetic model of the quotient, flags and latency.
module tb_fxp_sdiv;
    localparam int W  = 24;
    localparam int EW = 8 + 2 + W;   // {latency, div_by_zero, overflow, out}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    fxp_sdiv_if #(.BIT_WIDTH(W)) bus ();

    fxp_sdiv #(.QINT(8), .QFRAC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ov_count = 0;
    int rdy_mode = 0;    // 0: always ready, 1: random, 2: held by the test

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    logic          first_ov = 1'b1;
    logic          expect_idle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Reference: exact integer quotient, clipped to the signed output range.
    function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        longint sa, sb, q;
        logic [W-1:0] o;
        logic d, v;
        logic [7:0] lat;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        d = 1'b0;
        v = 1'b0;
        lat = 8'd41;
        if (sb == 0) begin
            d = 1'b1;
            lat = 8'd1;
            o = (sa < 0) ? 24'h800000 : 24'h7FFFFF;
        end else begin
            q = (sa * 65536) / sb;
            if (q > 64'sd8388607) begin
                o = 24'h7FFFFF;
                v = 1'b1;
            end else if (q < -64'sd8388608) begin
                o = 24'h800000;
                v = 1'b1;
            end else begin
                o = q[W-1:0];
            end
        end
        return {lat, d, v, o};
    endfunction

    // Compare process: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            first_ov = 1'b1;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("in_ready_after_take", {63'd0, bus.in_ready}, 64'd1);
                chk("out_valid_after_take", {63'd0, bus.out_valid}, 64'd0);
                expect_idle = 1'b0;
            end
            if (bus.out_valid) begin
                ov_count++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    chk("out", {40'd0, bus.out}, {40'd0, exp_q[0][W-1:0]});
                    chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, exp_q[0][W+1]});
                    chk("overflow", {63'd0, bus.overflow}, {63'd0, exp_q[0][W]});
                    chk("in_ready_in_done", {63'd0, bus.in_ready}, 64'd0);
                    if (first_ov) begin
                        chk("latency", 64'(cyc - acc_q[0]), {56'd0, exp_q[0][EW-1:W+2]});
                        first_ov = 1'b0;
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        first_ov = 1'b1;
                        expect_idle = 1'b1;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b));
                acc_q.push_back(cyc);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) bus.out_ready = 1'b1;
        else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_val);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a = ta;
        bus.b = tb_val;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 300) begin
                fail_now("accept_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        // Scramble operands after accept; the result must not change.
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) fail_now("result_wait");
    endtask

    logic [W-1:0] dir_a[8] = '{24'h030000, 24'hFF0000, 24'h800000, 24'h640000,
                               24'h9C0000, 24'hFE0000, 24'h010000, 24'h000000};
    logic [W-1:0] dir_b[8] = '{24'h020000, 24'h030000, 24'h010000, 24'h008000,
                               24'h008000, 24'h000000, 24'h000000, 24'hFD0000};

    initial begin
        logic [W-1:0] held_out;
        logic [W-1:0] ra, rb;
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out", {40'd0, bus.out}, 64'd0);
        chk("rst_div_by_zero", {63'd0, bus.div_by_zero}, 64'd0);
        chk("rst_overflow", {63'd0, bus.overflow}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Hand-computed values pinning the reference model.
        chk("model_3_div_2", 64'(model(24'h030000, 24'h020000)), {30'd0, 8'd41, 2'b00, 24'h018000});
        chk("model_m1_div_3", 64'(model(24'hFF0000, 24'h030000)), {30'd0, 8'd41, 2'b00, 24'hFFAAAB});
        chk("model_min_div_1", 64'(model(24'h800000, 24'h010000)), {30'd0, 8'd41, 2'b00, 24'h800000});
        chk("model_100_div_half", 64'(model(24'h640000, 24'h008000)), {30'd0, 8'd41, 2'b01, 24'h7FFFFF});
        chk("model_m100_div_half", 64'(model(24'h9C0000, 24'h008000)), {30'd0, 8'd41, 2'b01, 24'h800000});
        chk("model_m2_div_0", 64'(model(24'hFE0000, 24'h000000)), {30'd0, 8'd1, 2'b10, 24'h800000});
        chk("model_1_div_0", 64'(model(24'h010000, 24'h000000)), {30'd0, 8'd1, 2'b10, 24'h7FFFFF});

        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            issue(dir_a[i], dir_b[i]);
            wait_idle();
        end

        // Consumer stall in DONE, then a single-cycle out_ready pulse.
        rdy_mode = 2;
        bus.out_ready = 1'b0;
        issue(24'h030000, 24'h020000);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("stall_out_valid");
        held_out = bus.out;
        repeat (10) begin
            @(negedge clk);
            chk("stall_out_hold", {40'd0, bus.out}, {40'd0, held_out});
            chk("stall_valid_hold", {63'd0, bus.out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("pulse_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rdy_mode = 0;
        wait_idle();

        // Reset in the middle of an iteration run discards the operation.
        issue(24'h030000, 24'h020000);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = ov_count;
        repeat (60) @(posedge clk);
        #1;
        chk("no_result_after_rst", 64'(ov_count - n), 64'd0);
        issue(24'h030000, 24'h020000);
        wait_idle();

        // Random operands with a random consumer.
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: ra = 24'h800000;
                2: rb = W'($urandom_range(1, 255));
                3: rb = 24'h800000;
                4: ra = '0;
                default: ;
            endcase
            issue(ra, rb);
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
